sirv_gnrl_skid_buf: RTL

//  Two-entry valid/ready skid buffer between a producer and a consumer pipeline stage.
//  - Decides every cycle which data registers load; this is the control side of the enable-loaded register.
//  - Registers both o_vld/o_dat and i_rdy, so no combinational path exists between the two handshakes.
//  - Instantiated between core pipeline stages (IFU->EXU, LSU->BIU) where timing must be cut.

---
 rtl/sirv_gnrl_skid_buf_pkg.sv | 17 +
 rtl/sirv_gnrl_skid_buf_ent.sv | 25 ++
 rtl/sirv_gnrl_skid_buf.sv | 113 +++++++++++
 3 files changed

// File: rtl/sirv_gnrl_skid_buf_pkg.sv
// Shared definitions for the two-entry skid buffer: state encodings and bypass configuration.
// The optional zero-latency bypass is enabled by defining SIRV_SKID_BUF_BYPASS_EN.
package sirv_gnrl_skid_buf_pkg;

    typedef enum logic [1:0] {
        SKID_ST_EMPTY = 2'd0,
        SKID_ST_ONE   = 2'd1,
        SKID_ST_FULL  = 2'd2
    } skid_st_e;

`ifdef SIRV_SKID_BUF_BYPASS_EN
    localparam bit SKID_BYPASS_EN = 1'b1;
`else
    localparam bit SKID_BYPASS_EN = 1'b0;
`endif

endpackage

// File: rtl/sirv_gnrl_skid_buf_ent.sv
// One storage entry of the skid buffer: DW-wide register with load enable,
// asynchronously cleared to zero.
module sirv_skid_buf_ent #(
    parameter int DW = 32
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          i_en,
    input  logic [DW-1:0] i_d,
    output logic [DW-1:0] o_q
);

    logic [DW-1:0] r_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_q <= '0;
        end else if (i_en) begin
            r_q <= i_d;
        end
    end

    assign o_q = r_q;

endmodule

// File: rtl/sirv_gnrl_skid_buf.sv
// Two-entry valid/ready skid buffer cutting all combinational paths between the handshakes.
// Define SIRV_SKID_BUF_BYPASS_EN to forward i_dat straight to o_dat when empty and o_rdy is high.
//
// Handshake: a transfer happens on a clock edge where valid and ready are both high;
// i_vld while !i_rdy is ignored, o_rdy may change at any time, and o_dat is stable
// from the rise of o_vld until the output transfers.
module sirv_gnrl_skid_buf
    import sirv_gnrl_skid_buf_pkg::*;
#(
    parameter int DW = 32
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          i_vld,
    output logic          i_rdy,
    input  logic [DW-1:0] i_dat,
    output logic          o_vld,
    input  logic          o_rdy,
    output logic [DW-1:0] o_dat,
    output logic [1:0]    o_cnt
);

    skid_st_e      r_state;
    skid_st_e      w_state_nxt;
    logic          w_head_en;
    logic          w_skid_en;
    logic          w_head_from_skid;
    logic [DW-1:0] w_head_d;
    logic [DW-1:0] w_head_q;
    logic [DW-1:0] w_skid_q;
    logic          w_vld_reg;
    logic          w_i_xfer;
    logic          w_o_xfer;
    logic          w_bypass;

    // Flags decode the state register only, so neither handshake sees the other combinationally.
    assign i_rdy     = (r_state != SKID_ST_FULL);
    assign w_vld_reg = (r_state == SKID_ST_ONE) || (r_state == SKID_ST_FULL);
    assign w_i_xfer  = i_vld & i_rdy;
    assign w_o_xfer  = w_vld_reg & o_rdy;
    assign w_bypass  = SKID_BYPASS_EN && (r_state == SKID_ST_EMPTY) && i_vld && o_rdy;

    always_comb begin
        w_state_nxt      = r_state;
        w_head_en        = 1'b0;
        w_skid_en        = 1'b0;
        w_head_from_skid = 1'b0;
        case (r_state)
            SKID_ST_EMPTY: begin
                if (w_i_xfer && !w_bypass) begin
                    w_state_nxt = SKID_ST_ONE;
                    w_head_en   = 1'b1;
                end
            end
            SKID_ST_ONE: begin
                if (w_i_xfer && !w_o_xfer) begin
                    w_state_nxt = SKID_ST_FULL;
                    w_skid_en   = 1'b1;
                end else if (w_i_xfer && w_o_xfer) begin
                    w_head_en   = 1'b1;
                end else if (w_o_xfer) begin
                    w_state_nxt = SKID_ST_EMPTY;
                end
            end
            SKID_ST_FULL: begin
                if (w_o_xfer) begin
                    w_state_nxt      = SKID_ST_ONE;
                    w_head_en        = 1'b1;
                    w_head_from_skid = 1'b1;
                end
            end
            default: w_state_nxt = SKID_ST_EMPTY;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= SKID_ST_EMPTY;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    assign w_head_d = w_head_from_skid ? w_skid_q : i_dat;

    sirv_skid_buf_ent #(.DW(DW)) u_head (
        .clk   (clk),
        .rst_n (rst_n),
        .i_en  (w_head_en),
        .i_d   (w_head_d),
        .o_q   (w_head_q)
    );

    sirv_skid_buf_ent #(.DW(DW)) u_skid (
        .clk   (clk),
        .rst_n (rst_n),
        .i_en  (w_skid_en),
        .i_d   (i_dat),
        .o_q   (w_skid_q)
    );

`ifdef SIRV_SKID_BUF_BYPASS_EN
    assign o_vld = w_bypass ? i_vld : w_vld_reg;
    assign o_dat = w_bypass ? i_dat : w_head_q;
`else
    assign o_vld = w_vld_reg;
    assign o_dat = w_head_q;
`endif

    // The state encoding doubles as the occupancy count.
    assign o_cnt = r_state;

endmodule
